// File: rtl/key_debounce_array_if.sv
// ----------------------------------------------------------------------------
// key_debounce_array_if
//   Bundles the raw key pins and the per-channel debounced results of
//   key_debounce_array into one interface.
//
//   Parameter
//     KEY_NUM        number of key channels (1..32)
//
//   Signals (all KEY_NUM wide, bit i = channel i)
//     key_in         raw asynchronous key pins
//     key_state      debounced level, 1 = pressed
//     press_pulse    one-cycle strobe on a debounced press
//     release_pulse  one-cycle strobe on a debounced release
//     toggle_q       level that inverts after every press_pulse
//     long_pulse     one-cycle strobe at the long-press threshold
//
//   Modports
//     master         drives key_in, observes the results (board / bench side)
//     slave          samples key_in, drives the results (debouncer side)
// ----------------------------------------------------------------------------
interface key_debounce_array_if #(
    parameter int KEY_NUM = 4
);
    logic [KEY_NUM-1:0] key_in;
    logic [KEY_NUM-1:0] key_state;
    logic [KEY_NUM-1:0] press_pulse;
    logic [KEY_NUM-1:0] release_pulse;
    logic [KEY_NUM-1:0] toggle_q;
    logic [KEY_NUM-1:0] long_pulse;

    modport master (
        output key_in,
        input  key_state,
        input  press_pulse,
        input  release_pulse,
        input  toggle_q,
        input  long_pulse
    );

    modport slave (
        input  key_in,
        output key_state,
        output press_pulse,
        output release_pulse,
        output toggle_q,
        output long_pulse
    );
endinterface

// File: rtl/key_debounce_array.sv
// ----------------------------------------------------------------------------
// key_debounce_array
//   KEY_NUM independent key debouncers. Each channel synchronises its raw pin,
//   waits for the level to stay stable for CNT_MAX cycles, then commits it to
//   key_state and emits press/release strobes plus a press-toggled level.
//
//   Optional feature (compile-time macro KEY_LONG_PRESS_EN):
//     defined   - per-channel saturating hold counter; long_pulse fires once,
//                 LONG_MAX cycles after the press_pulse cycle.
//     undefined - long_pulse is tied to 0 and no hold counters exist.
//
//   Parameters
//     KEY_NUM     number of channels (1..32)
//     CNT_MAX     debounce window in clk cycles (>= 2)
//     ACTIVE_LOW  1: a pressed key reads 0 on key_in
//     LONG_MAX    long-press threshold in clk cycles
//
//   Ports
//     clk         system clock, rising edge
//     rst_n       asynchronous active-low reset
//     bus         key_debounce_array_if.slave (key_in in, results out)
//
//   Latency: a clean transition on key_in reaches key_state on the
//   (CNT_MAX+2)th rising edge, counting the first edge that samples the new
//   level as edge 1 (two sync flops, one reload edge, CNT_MAX-1 decrements).
// ----------------------------------------------------------------------------

// Single debounce channel.
module key_debounce_ch #(
    parameter int CNT_MAX    = 1_000_000,
    parameter int ACTIVE_LOW = 1,
    parameter int LONG_MAX   = 50_000_000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic key_in,
    output logic key_state,
    output logic press_pulse,
    output logic release_pulse,
    output logic toggle_q,
    output logic long_pulse
);
    localparam int   CW      = $clog2(CNT_MAX + 1);
    // Pin level of a released key; the synchroniser resets to it so that
    // reset release never looks like a transition of an idle key.
    localparam logic REL_LVL = (ACTIVE_LOW != 0) ? 1'b1 : 1'b0;

    logic          d0, d1;
    logic [CW-1:0] cnt;
    logic          pressed_lvl;
    logic          commit;

    assign pressed_lvl = (ACTIVE_LOW != 0) ? ~d1 : d1;
    // The counter only reaches 1 after d1 has held for the full window.
    assign commit      = (cnt == CW'(1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            d0            <= REL_LVL;
            d1            <= REL_LVL;
            cnt           <= '0;
            key_state     <= 1'b0;
            press_pulse   <= 1'b0;
            release_pulse <= 1'b0;
            toggle_q      <= 1'b0;
        end else begin
            d0 <= key_in;
            d1 <= d0;

            // Any difference between the sync stages restarts the window;
            // otherwise count down and park at 0.
            if (d1 != d0)
                cnt <= CW'(CNT_MAX);
            else if (cnt != '0)
                cnt <= cnt - CW'(1);

            if (commit)
                key_state <= pressed_lvl;

            // Strobes are registered alongside key_state so they coincide
            // with its first cycle at the new level. A commit of the level
            // already held (bounce back) changes nothing.
            press_pulse   <= commit &  pressed_lvl & ~key_state;
            release_pulse <= commit & ~pressed_lvl &  key_state;

            // Inverts on the edge after press_pulse.
            toggle_q <= toggle_q ^ press_pulse;
        end
    end

`ifdef KEY_LONG_PRESS_EN
    localparam int HW = $clog2(LONG_MAX + 1);

    logic [HW-1:0] hold;

    // hold counts cycles since key_state rose: after press edge P it reads k
    // following edge P+k. Saturating at LONG_MAX keeps it from ever matching
    // LONG_MAX-1 again, so long_pulse fires once per press.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold       <= '0;
            long_pulse <= 1'b0;
        end else begin
            if (!key_state)
                hold <= '0;
            else if (hold != HW'(LONG_MAX))
                hold <= hold + HW'(1);

            long_pulse <= key_state && (hold == HW'(LONG_MAX - 1));
        end
    end
`else
    // Feature compiled out; the comparison is constant 0 and keeps LONG_MAX
    // referenced so the parameter list stays identical in both builds.
    assign long_pulse = (LONG_MAX < 0);
`endif

endmodule

// Top: one channel per key, results gathered onto the interface.
module key_debounce_array #(
    parameter int KEY_NUM    = 4,
    parameter int CNT_MAX    = 1_000_000,
    parameter int ACTIVE_LOW = 1,
    parameter int LONG_MAX   = 50_000_000
) (
    input  logic                  clk,
    input  logic                  rst_n,
    key_debounce_array_if.slave   bus
);
    logic [KEY_NUM-1:0] key_state;
    logic [KEY_NUM-1:0] press_pulse;
    logic [KEY_NUM-1:0] release_pulse;
    logic [KEY_NUM-1:0] toggle_q;
    logic [KEY_NUM-1:0] long_pulse;

    for (genvar i = 0; i < KEY_NUM; i++) begin : g_ch
        key_debounce_ch #(
            .CNT_MAX    (CNT_MAX),
            .ACTIVE_LOW (ACTIVE_LOW),
            .LONG_MAX   (LONG_MAX)
        ) u_ch (
            .clk           (clk),
            .rst_n         (rst_n),
            .key_in        (bus.key_in[i]),
            .key_state     (key_state[i]),
            .press_pulse   (press_pulse[i]),
            .release_pulse (release_pulse[i]),
            .toggle_q      (toggle_q[i]),
            .long_pulse    (long_pulse[i])
        );
    end

    assign bus.key_state     = key_state;
    assign bus.press_pulse   = press_pulse;
    assign bus.release_pulse = release_pulse;
    assign bus.toggle_q      = toggle_q;
    assign bus.long_pulse    = long_pulse;

endmodule

// File: doc/key_debounce_array.md
KEY_DEBOUNCE_ARRAY -- requirements
Module: key_debounce_array

Interface
REQ-001 The block SHALL provide parameter KEY_NUM, default 4, the number of independent key channels (1..32).
REQ-002 The block SHALL provide parameter CNT_MAX, default 1_000_000, the debounce window in clk cycles (20 ms at 50 MHz, minimum 2).
REQ-003 The block SHALL provide parameter ACTIVE_LOW, default 1, where 1 means a pressed key reads 0 on key_in.
REQ-004 The block SHALL provide parameter LONG_MAX, default 50_000_000, the long-press threshold in clk cycles (1 s at 50 MHz).
REQ-005 clk  input  1  system clock, all logic rising-edge.
REQ-006 rst_n  input  1  reset, asynchronous, active-low.
REQ-007 key_in  input  KEY_NUM  raw asynchronous key pins.
REQ-008 key_state  output  KEY_NUM  debounced level per channel, 1 = pressed.
REQ-009 press_pulse  output  KEY_NUM  one-cycle strobe on a debounced press.
REQ-010 release_pulse  output  KEY_NUM  one-cycle strobe on a debounced release.
REQ-011 toggle_q  output  KEY_NUM  per-channel level that inverts on every press_pulse.
REQ-012 long_pulse  output  KEY_NUM  one-cycle strobe at long-press threshold (see Configuration).

Function
REQ-013 Each channel SHALL pass key_in through a two-flop synchroniser (d0, d1) before any other use.
REQ-014 Each channel SHALL have a down-counter of width clog2(CNT_MAX+1), loaded with CNT_MAX on any cycle where d1 != d0.
REQ-015 When d1 == d0, the counter SHALL decrement by 1 and saturate at 0, with no wrap-around.
REQ-016 On the edge where the counter equals 1, the channel SHALL commit d1 (converted to pressed = 1 via ACTIVE_LOW) into key_state.
REQ-017 With a clean transition, key_state SHALL update on the (CNT_MAX+2)th rising edge, counting the first edge that samples the new key_in level as edge 1.
REQ-018 Any bounce inside the window SHALL reload the counter, so a level held for fewer than CNT_MAX cycles never reaches key_state.
REQ-019 press_pulse[i] SHALL be registered at the same edge where key_state[i] goes 0->1, giving exactly 1 cycle high, coincident with the first cycle key_state[i]=1.
REQ-020 release_pulse[i] SHALL follow the same rule as press_pulse, for the 1->0 change of key_state[i].
REQ-021 A commit that equals the current key_state (input bounced back to the old level) SHALL produce no pulse.
REQ-022 toggle_q[i] SHALL invert on the edge after press_pulse[i] is high; releases SHALL not affect it.
REQ-023 Channels SHALL be fully independent, so simultaneous events on several channels SHALL produce their pulses in the same cycle.

Reset
REQ-024 While rst_n = 0, d0 and d1 SHALL hold the released level, counters SHALL be 0, and key_state, press_pulse, release_pulse, toggle_q, long_pulse and the hold counters SHALL be 0.
REQ-025 Reset asserted mid-window SHALL discard the pending commit; after release, a key already held SHALL be debounced afresh and produce a press_pulse after the normal latency.

Configuration
REQ-026 Macro KEY_LONG_PRESS_EN defined: each channel SHALL have a saturating hold counter that counts while key_state[i]=1 and clears when key_state[i]=0.
REQ-027 Macro KEY_LONG_PRESS_EN defined: long_pulse[i] SHALL assert exactly once, for 1 cycle, LONG_MAX cycles after the press_pulse[i] cycle, and never again until after a release.
REQ-028 Macro KEY_LONG_PRESS_EN undefined: the long_pulse port SHALL remain and be tied to 0, and no hold counters SHALL be synthesised.

Verification (KEY_NUM=4, CNT_MAX=8, LONG_MAX=32, ACTIVE_LOW=1)
REQ-029 Reset: hold rst_n=0 with key_in=4'b0000 -> all outputs 0; release reset, key_in held 0 -> press_pulse=4'b1111 on edge 10 after reset release, all in one cycle.
REQ-030 Clean press: key_in[0] 1->0 and held 20 cycles -> key_state[0]=1 on edge 10, press_pulse[0] high 1 cycle, toggle_q[0]=1 next edge; on release 1 -> release_pulse[0] 10 edges later, toggle_q[0] stays 1.
REQ-031 Bounce: key_in[1] toggled every 3 cycles for 40 cycles then left at 1 -> no pulses and key_state[1]=0 throughout.
REQ-032 Simultaneous: key_in[1] and key_in[3] fall on the same edge -> press_pulse=4'b1010 in a single cycle.
REQ-033 Long press: key_in[2]=0 held 80 cycles -> long_pulse[2] high exactly once, 32 cycles after press_pulse[2], when built with KEY_LONG_PRESS_EN; long_pulse stays 0 throughout when built without it.
REQ-034 Reset mid-window: key_in[0] falls, rst_n pulsed low at edge 5 -> no press_pulse from the first window; press_pulse[0] 10 edges after rst_n release.
